alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_core.sv | 62 ++++++
 rtl/alu_pipe.sv | 104 ++++++++++
 tb/tb_alu_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode encodings and the result-flag bundle shared by alu_core, alu_pipe and the bench.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
    logic parity;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and flags from a, b, opcode; no state, no handshake.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  logic [WIDTH:0] ext;
  logic           carry;
  logic           ovf;

  always_comb begin
    ext    = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (opcode)
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    flags          = '0;
    flags.sign     = result[WIDTH-1];
    flags.zero     = (result == '0);
    flags.carry    = carry;
    flags.parity   = ~^result;
    flags.overflow = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU (operand reg, result reg): accept at edge N, result handshake at edge N+2; whole pipe
// holds while out_valid && !out_ready. Define ALU_PIPE_ACC_EN to add an accumulator selectable as operand A.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  logic             stall;
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] res;
  flags_t           res_flags;
  flags_t           flags_q;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

`ifdef ALU_PIPE_ACC_EN
  logic [WIDTH-1:0] acc;

  // Only retired results land here; in-flight results are deliberately not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (out_valid && out_ready) begin
      acc <= out;
    end
  end

  assign op_a = acc_sel ? acc : a;
`else
  logic unused_acc_sel;
  assign unused_acc_sel = acc_sel;
  assign op_a           = a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_op  <= OP_ADD;
    end else if (!stall) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a  <= op_a;
        s1_b  <= b;
        s1_op <= opcode;
      end
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .opcode (s1_op),
    .result (res),
    .flags  (res_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      flags_q   <= '0;
    end else if (!stall) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out     <= res;
        flags_q <= res_flags;
      end
    end
  end

  assign sign     = flags_q.sign;
  assign zero     = flags_q.zero;
  assign carry    = flags_q.carry;
  assign parity   = flags_q.parity;
  assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: an 8-bit and a 16-bit instance, directed vectors plus a queue-based reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    int         dut;
    longint     out;
    logic [4:0] fl;
    longint     acc_edge;
    longint     stall_at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  iv, ir, ov, ordy, ordy_eff, sel;
  logic [63:0] av [2];
  logic [63:0] bv [2];
  logic [2:0]  opv [2];
  logic        pat_en;
  logic [7:0]  out8;
  logic [15:0] out16;
  logic        s8, z8, c8, p8, v8, s16, z16, c16, p16, v16;
  logic [63:0] outv [2];
  logic [4:0]  flv [2];

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  exp_t   q[$];
  longint stall_cnt [2] = '{0, 0};
  longint acc_m [2] = '{0, 0};
  int     acc_cnt [2] = '{0, 0};
  int     ret_cnt [2] = '{0, 0};
  logic [1:0] prev_ov = 2'b00;
  logic [1:0] prev_hs = 2'b00;

  logic [7:0]  lit8  [8] = '{8'h10, 8'hFA, 8'h01, 8'h0F, 8'h0E, 8'hFA, 8'h0A, 8'h02};
  logic [4:0]  litf  [8] = '{5'b00000, 5'b10110, 5'b00000, 5'b00010, 5'b00000, 5'b10010, 5'b00010, 5'b00100};
  logic [15:0] va16  [8] = '{16'h7FFF, 16'h0000, 16'h8000, 16'hF0F0, 16'h00FF, 16'h1234, 16'hC000, 16'h0003};
  logic [15:0] vb16  [8] = '{16'h0001, 16'h0001, 16'h0001, 16'hFF00, 16'h0F00, 16'h0000, 16'h0000, 16'h0000};
  logic [2:0]  ops16 [8] = '{OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_SHL, OP_SHR};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ordy_eff = {ordy[1] & ~(pat_en && (cyc % 3 == 2)), ordy[0]};
  assign outv[0]  = {56'd0, out8};
  assign outv[1]  = {48'd0, out16};
  assign flv[0]   = {s8, z8, c8, p8, v8};
  assign flv[1]   = {s16, z16, c16, p16, v16};

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .opcode(opv[0]), .acc_sel(sel[0]),
    .out_valid(ov[0]), .out_ready(ordy_eff[0]), .out(out8),
    .sign(s8), .zero(z8), .carry(c8), .parity(p8), .overflow(v8)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][15:0]), .b(bv[1][15:0]), .opcode(opv[1]), .acc_sel(sel[1]),
    .out_valid(ov[1]), .out_ready(ordy_eff[1]), .out(out16),
    .sign(s16), .zero(z16), .carry(c16), .parity(p16), .overflow(v16)
  );

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Reference arithmetic on plain integers: signed ranges for overflow, unsigned compare for borrow.
  function automatic void model(input int w, input longint a, input longint b, input logic [2:0] op,
                                output longint r, output logic [4:0] fl);
    longint m, half, sa, sb, t;
    bit c, v;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - (m + 1) : a;
    sb   = (b >= half) ? b - (m + 1) : b;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      OP_ADD: begin t = a + b; r = t & m; c = t > m; v = (sa + sb > half - 1) || (sa + sb < -half); end
      OP_SUB: begin r = (a - b) & m; c = a < b; v = (sa - sb > half - 1) || (sa - sb < -half); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a & m;
      OP_SHL: begin r = (a << 1) & m; c = a >= half; end
      default: begin r = a >> 1; c = (a % 2) == 1; end
    endcase
    fl = {r >= half, r == 0, c, ($countones(r) % 2) == 0, v};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_ov = 2'b00;
      prev_hs = 2'b00;
      for (int k = 0; k < 2; k++) begin
        acc_m[k] = 0; acc_cnt[k] = 0; ret_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int         w, idx;
        bit         take;
        longint     opa, r;
        logic [4:0] f;
        exp_t       e;
        w = (k == 0) ? 8 : 16;
        chk(ir[k] == !(ov[k] && !ordy_eff[k]), "in_ready_rule", 64'(ir[k]), 64'(!(ov[k] && !ordy_eff[k])));
        take = iv[k] && ir[k];
        r = 0; f = '0;
        if (take) begin
`ifdef ALU_PIPE_ACC_EN
          opa = sel[k] ? acc_m[k] : longint'(av[k]);
`else
          opa = longint'(av[k]);
`endif
          model(w, opa, longint'(bv[k]), opv[k], r, f);
        end
        idx = -1;
        foreach (q[i]) if (idx < 0 && q[i].dut == k) idx = i;
        if (ov[k]) begin
          chk(idx >= 0, "valid_without_accept", 64'(ov[k]), 64'd0);
          if (idx >= 0) begin
            e = q[idx];
            if (!prev_ov[k] || prev_hs[k])
              chk(cyc == e.acc_edge + 1 + (stall_cnt[k] - e.stall_at), "latency",
                  64'(cyc), 64'(e.acc_edge + 1 + (stall_cnt[k] - e.stall_at)));
            chk(outv[k] == 64'(e.out), "model_out", outv[k], 64'(e.out));
            chk(flv[k] == e.fl, "model_flags", 64'(flv[k]), 64'(e.fl));
            if (ordy_eff[k]) begin
              acc_m[k] = e.out;
              q.delete(idx);
              ret_cnt[k]++;
            end
          end
        end
        if (take) begin
          e.dut = k; e.out = r; e.fl = f; e.acc_edge = cyc + 1; e.stall_at = stall_cnt[k];
          q.push_back(e);
          acc_cnt[k]++;
        end
        prev_ov[k] = ov[k];
        prev_hs[k] = ov[k] && ordy_eff[k];
        if (ov[k] && !ordy_eff[k]) stall_cnt[k]++;
      end
    end
  end

  task automatic send(input int k, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op, input logic s);
    bit got;
    int tries;
    got = 1'b0; tries = 0;
    iv[k] = 1'b1; av[k] = a; bv[k] = b; opv[k] = op; sel[k] = s;
    while (!got && tries < 50) begin
      @(negedge clk);
      got = ir[k];
      @(posedge clk); #1;
      tries++;
    end
    chk(got, "accept", 64'(got), 64'd1);
  endtask

  task automatic one(input int k, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op, input logic s,
                     input logic [63:0] xo, input logic [4:0] xf, input string nm);
    send(k, a, b, op, s);
    iv[k] = 1'b0;
    sel[k] = 1'b0;
    @(posedge clk); #1;
    chk(ov[k] == 1'b1, {nm, "_valid"}, 64'(ov[k]), 64'd1);
    chk(outv[k] == xo, {nm, "_out"}, outv[k], xo);
    chk(flv[k] == xf, {nm, "_flags"}, 64'(flv[k]), 64'(xf));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || ov != 2'b00) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(q.size() == 0 && ov == 2'b00, "drain", 64'(q.size()), 64'd0);
  endtask

  task automatic check_cleared(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk(ov[k] == 1'b0, {nm, "_out_valid"}, 64'(ov[k]), 64'd0);
      chk(outv[k] == 64'd0, {nm, "_out"}, outv[k], 64'd0);
      chk(flv[k] == 5'd0, {nm, "_flags"}, 64'(flv[k]), 64'd0);
      chk(ir[k] == 1'b1, {nm, "_in_ready"}, 64'(ir[k]), 64'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    longint     mr;
    logic [4:0] mf;
    rst_n = 1'b0; iv = 2'b00; ordy = 2'b11; sel = 2'b00; pat_en = 1'b0;
    for (int k = 0; k < 2; k++) begin av[k] = '0; bv[k] = '0; opv[k] = OP_ADD; end

    model(8, 5, 11, OP_SUB, mr, mf);
    chk(mr == 'hFA && mf == 5'b10110, "model_pin_sub", 64'(mr), 64'hFA);
    model(8, 'h7F, 1, OP_ADD, mr, mf);
    chk(mr == 'h80 && mf == 5'b10001, "model_pin_ovf", 64'(mf), 64'h11);
    model(16, 'h8001, 0, OP_SHR, mr, mf);
    chk(mr == 'h4000 && mf == 5'b00100, "model_pin_shr", 64'(mr), 64'h4000);

    #3;
    check_cleared("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int op = 0; op < 8; op++)
      one(0, 64'd5, 64'd11, 3'(op), 1'b0, 64'(lit8[op]), litf[op], $sformatf("op%0d", op));

    one(0, 64'h7F, 64'h01, OP_ADD, 1'b0, 64'h80, 5'b10001, "add_ovf");
    one(0, 64'hFF, 64'h01, OP_ADD, 1'b0, 64'h00, 5'b01110, "add_wrap");

    one(1, 64'h8001, 64'd0, OP_SHL, 1'b0, 64'h0002, 5'b00100, "shl16");
    one(1, 64'h8001, 64'd0, OP_SHR, 1'b0, 64'h4000, 5'b00100, "shr16");

    one(0, 64'd3, 64'd4, OP_ADD, 1'b0, 64'd7, 5'b00000, "acc_seed");
`ifdef ALU_PIPE_ACC_EN
    one(0, 64'd0, 64'd1, OP_ADD, 1'b1, 64'd8, 5'b00000, "acc_use");
`else
    one(0, 64'd0, 64'd1, OP_ADD, 1'b1, 64'd1, 5'b00000, "acc_ignored");
`endif

    // Stall: first result parked at the output, second held in the operand stage.
    ordy[0] = 1'b0;
    send(0, 64'h10, 64'h20, OP_ADD, 1'b0);
    send(0, 64'h0F, 64'h01, OP_SUB, 1'b0);
    av[0] = 64'h33; bv[0] = 64'h44; opv[0] = OP_XOR;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk(ir[0] == 1'b0, "stall_in_ready", 64'(ir[0]), 64'd0);
      chk(outv[0] == 64'h30, "stall_out_held", outv[0], 64'h30);
      chk(flv[0] == 5'b00010, "stall_flags_held", 64'(flv[0]), 64'h02);
      chk(acc_cnt[0] - ret_cnt[0] == 2, "stall_pending", 64'(acc_cnt[0] - ret_cnt[0]), 64'd2);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    send(0, 64'h33, 64'h44, OP_XOR, 1'b0);
    send(0, 64'h80, 64'h80, OP_ADD, 1'b0);
    send(0, 64'h00, 64'h00, OP_SHR, 1'b0);
    iv[0] = 1'b0;
    drain();
    chk(acc_cnt[0] == ret_cnt[0], "stall_none_lost", 64'(ret_cnt[0]), 64'(acc_cnt[0]));

    pat_en = 1'b1;
    for (int i = 0; i < 8; i++) send(1, 64'(va16[i]), 64'(vb16[i]), ops16[i], 1'b0);
    iv[1] = 1'b0;
    drain();
    pat_en = 1'b0;
    chk(acc_cnt[1] == ret_cnt[1], "stream16_none_lost", 64'(ret_cnt[1]), 64'(acc_cnt[1]));

    send(0, 64'd9, 64'd9, OP_ADD, 1'b0);
    iv[0] = 1'b0;
    @(posedge clk); #1;
    chk(ov[0] == 1'b1, "pre_reset_valid", 64'(ov[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk(ov == 2'b00, "post_reset_quiet", 64'(ov), 64'd0);
    end
    @(posedge clk); #1;
    one(0, 64'd1, 64'd1, OP_ADD, 1'b0, 64'd2, 5'b00000, "after_reset");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
